bicubic_sched: RTL and testbench
================================

BICUBIC_SCHED -- requirements
Module: bicubic_sched

Interface
REQ-001 Parameter LAT, default 1: cycles from wt_issue to a valid wt_sum; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 win_valid  input  1  4x4 source window offered.
REQ-005 win_ready  output  1  block can accept a window.
REQ-006 win_data  input  128  pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)], unsigned 8-bit.
REQ-007 wt_issue  output  1  strobe: wt_in_0..3 hold a valid tap set this cycle.
REQ-008 wt_in_0 .. wt_in_3  output  15 each  weight-table taps, unsigned 8.7 fixed point.
REQ-009 wt_sum  input  17  weight-table result, two's complement, 7 fractional bits.
REQ-010 out_valid  output  1  interpolated pixel available.
REQ-011 out_ready  input  1  consumer accepts out_pixel.
REQ-012 out_pixel  output  8  interpolated pixel, unsigned.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, H_ISSUE, H_WAIT, V_ISSUE, V_WAIT and OUT.
REQ-015 win_ready SHALL be 1 only in IDLE; a window is accepted on win_valid && win_ready at cycle T and registered internally.
REQ-016 H_ISSUE SHALL occupy cycles T+1..T+4, issuing row r (r=0..3) at cycle T+1+r with wt_in_k = {pixel(r,k), 7'b0} and wt_issue=1.
REQ-017 The block SHALL capture wt_sum LAT cycles after each issue into row_res[r]; H_WAIT holds until row_res[3] is captured at T+4+LAT.
REQ-018 Each row_res SHALL be clamped to 15-bit unsigned before reuse: negative -> 0; value > 32767 -> 32767.
REQ-019 V_ISSUE SHALL be one cycle, T+5+LAT, with wt_in_k = clamped row_res[k] and wt_issue=1.
REQ-020 V_WAIT SHALL capture wt_sum at T+5+2*LAT as v_res.
REQ-021 out_pixel SHALL be computed from v_res as follows: negative -> 0; otherwise (v_res + 64) >> 7, saturated to 255.
REQ-022 out_valid SHALL rise at T+6+2*LAT (T+8 for LAT=1) in OUT, and out_pixel SHALL stay stable while out_valid && !out_ready.
REQ-023 On out_valid && out_ready the FSM SHALL go to IDLE; the next window can be accepted the following cycle at the earliest, with no same-cycle bypass.
REQ-024 When wt_issue=0, wt_in_0..3 SHALL be driven to 0.
REQ-025 wt_sum SHALL be ignored on every cycle that is not a scheduled capture cycle.
REQ-026 win_valid seen outside IDLE SHALL have no effect, and win_data SHALL be sampled only at acceptance.

Reset
REQ-027 While rst=1, on the next edge the block SHALL enter IDLE with win_ready=1, busy=0, wt_issue=0, wt_in_0..3=0, out_valid=0, out_pixel=0, and row_res/v_res cleared.
REQ-028 rst asserted in any state SHALL abort the operation in progress; no out_valid is produced for the aborted window.

Verification
Bench stub for all scenarios: LAT=1, wt_sum registered = {2'b00, wt_in_1}, unless overridden.

REQ-029 All 16 pixels = 255, out_ready=1 -> issue taps 32640 on cycles T+1..T+4 and at T+6; out_valid=1 only at T+8 with out_pixel=255; busy low at T+9.
REQ-030 Column 1 = 20,30,25,55 (rows 0..3), other pixels 0 -> V_ISSUE taps 2560,3840,3200,7040 -> v_res=3840 -> out_pixel=30.
REQ-031 Stub overridden to output 17'h1FF80 (-1.0) -> every row_res clamps to 0 -> out_pixel=0. Stub overridden to 17'h0FFFF -> rows clamp to 32767 -> (32767+64)>>7=256 -> out_pixel=255.
REQ-032 Rounding: stub v_res = 2624 (20.5) -> out_pixel=21; v_res = 2623 -> out_pixel=20.
REQ-033 out_ready held 0 for 5 cycles after out_valid -> out_valid and out_pixel stable, win_ready=0, a new win_valid is ignored; out_ready=1 -> IDLE next cycle, and the next window is accepted one cycle later.
REQ-034 rst pulsed at T+3 mid H_ISSUE -> state at T+4 matches REQ-027, no out_valid follows; a new all-255 window then produces 255 at T'+8.

Source files
------------

// File: rtl/bicubic_sched.sv
`default_nettype none
// =============================================================================
// bicubic_sched : schedules four row passes and one column pass of a 4x4
//                 bicubic window through an external weight-table pipeline.
// Rev 1.0
// =============================================================================
module bicubic_sched #(
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         win_valid,
  output logic         win_ready,
  input  logic [127:0] win_data,
  output logic         wt_issue,
  output logic [14:0]  wt_in_0,
  output logic [14:0]  wt_in_1,
  output logic [14:0]  wt_in_2,
  output logic [14:0]  wt_in_3,
  input  logic [16:0]  wt_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_pixel,
  output logic         busy
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_H_ISSUE = 3'd1;
  localparam logic [2:0] S_H_WAIT  = 3'd2;
  localparam logic [2:0] S_V_ISSUE = 3'd3;
  localparam logic [2:0] S_V_WAIT  = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;

  logic [2:0]     r_state;
  logic [127:0]   r_win;
  logic [1:0]     r_row;
  logic [LAT-1:0] r_cap_pipe;
  logic [2:0]     r_cap_idx;
  logic [16:0]    r_row_res [4];
  logic [16:0]    r_v_res;

  logic           w_cap;
  logic [14:0]    w_tap [4];
  logic [10:0]    w_scaled;

  function automatic logic [14:0] clamp15(input logic [16:0] v);
    if (v[16])      return 15'd0;
    else if (v[15]) return 15'h7FFF;
    else            return v[14:0];
  endfunction

  // A result is due exactly LAT cycles after every issue strobe.
  assign w_cap     = r_cap_pipe[LAT-1];
  assign win_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);

  assign w_scaled  = 11'(({1'b0, r_v_res} + 18'd64) >> 7);
  assign out_pixel = r_v_res[16]      ? 8'd0 :
                     (|w_scaled[10:8]) ? 8'd255 : w_scaled[7:0];

  always_comb begin
    wt_issue = 1'b0;
    for (int k = 0; k < 4; k++) w_tap[k] = 15'd0;
    if (r_state == S_H_ISSUE) begin
      wt_issue = 1'b1;
      for (int k = 0; k < 4; k++)
        w_tap[k] = {r_win[8*(4*int'(r_row)+k) +: 8], 7'b0};
    end else if (r_state == S_V_ISSUE) begin
      wt_issue = 1'b1;
      for (int k = 0; k < 4; k++) w_tap[k] = clamp15(r_row_res[k]);
    end
  end

  assign wt_in_0 = w_tap[0];
  assign wt_in_1 = w_tap[1];
  assign wt_in_2 = w_tap[2];
  assign wt_in_3 = w_tap[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_row      <= '0;
      r_cap_pipe <= '0;
      r_cap_idx  <= '0;
      r_v_res    <= '0;
      for (int k = 0; k < 4; k++) r_row_res[k] <= '0;
    end else begin
      r_cap_pipe[0] <= wt_issue;
      for (int i = 1; i < LAT; i++) r_cap_pipe[i] <= r_cap_pipe[i-1];

      // Captures 0..3 are the row passes, capture 4 is the column pass.
      if (w_cap) begin
        if (r_cap_idx[2]) r_v_res <= wt_sum;
        else              r_row_res[r_cap_idx[1:0]] <= wt_sum;
        r_cap_idx <= r_cap_idx + 3'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (win_valid) begin
            r_win     <= win_data;
            r_row     <= 2'd0;
            r_cap_idx <= 3'd0;
            r_state   <= S_H_ISSUE;
          end
        end
        S_H_ISSUE: begin
          r_row <= r_row + 2'd1;
          if (r_row == 2'd3) r_state <= S_H_WAIT;
        end
        S_H_WAIT: begin
          if (w_cap && (r_cap_idx == 3'd3)) r_state <= S_V_ISSUE;
        end
        S_V_ISSUE: r_state <= S_V_WAIT;
        S_V_WAIT: begin
          if (w_cap && (r_cap_idx == 3'd4)) r_state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bicubic_sched.sv
`default_nettype none
// tb_bicubic_sched: directed vectors against a registered weight-table stub
// (LAT=1, wt_sum = {2'b00, wt_in_1} one cycle after issue, optionally forced).
module tb_bicubic_sched;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         win_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] win_data = '0;
  logic         win_ready, wt_issue, out_valid, busy;
  logic [14:0]  wt_in_0, wt_in_1, wt_in_2, wt_in_3;
  logic [16:0]  wt_sum;
  logic [16:0]  stub_q = '0;
  logic [7:0]   out_pixel;
  logic         ovr_en = 1'b0;
  logic [16:0]  ovr_val = '0;
  logic [3:0][14:0] taps;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0]     data;
    logic             ovr;
    logic [16:0]      ov;
    logic [3:0][14:0] vt;
    logic [7:0]       pix;
  } vec_t;

  vec_t vecs [7];

  bicubic_sched #(.LAT(1)) dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .wt_issue(wt_issue),
    .wt_in_0(wt_in_0), .wt_in_1(wt_in_1), .wt_in_2(wt_in_2), .wt_in_3(wt_in_3),
    .wt_sum(wt_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) stub_q <= {2'b00, wt_in_1};
  assign wt_sum = ovr_en ? ovr_val : stub_q;
  assign taps   = {wt_in_3, wt_in_2, wt_in_1, wt_in_0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [127:0] d, input logic o, input logic [16:0] ov,
                              input logic [3:0][14:0] vt, input logic [7:0] pix);
    vec_t v;
    v.data = d; v.ovr = o; v.ov = ov; v.vt = vt; v.pix = pix;
    return v;
  endfunction

  // Offers one window, then checks every cycle T+1..T+9 of the transaction.
  task automatic do_window(input vec_t v, input int id);
    logic iss_exp;
    ovr_en = v.ovr; ovr_val = v.ov; out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d_win_ready", id), win_ready, 1);
    win_valid = 1'b1; win_data = v.data;
    @(negedge clk);
    win_valid = 1'b0; win_data = '0;
    for (int k = 1; k <= 9; k++) begin
      iss_exp = (k <= 4) || (k == 6);
      chk($sformatf("v%0d_issue_T%0d", id, k), wt_issue, iss_exp);
      if (k <= 4) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("v%0d_htap_r%0d_k%0d", id, k-1, j), taps[j],
              {v.data[8*(4*(k-1)+j) +: 8], 7'b0});
      end else if (k == 6) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("v%0d_vtap_k%0d", id, j), taps[j], v.vt[j]);
      end else begin
        chk($sformatf("v%0d_taps_idle_T%0d", id, k), taps, 0);
      end
      chk($sformatf("v%0d_out_valid_T%0d", id, k), out_valid, k == 8);
      if (k == 8) chk($sformatf("v%0d_out_pixel", id), out_pixel, v.pix);
      if (k == 9) begin
        chk($sformatf("v%0d_busy_after", id), busy, 0);
        chk($sformatf("v%0d_ready_after", id), win_ready, 1);
      end
      @(negedge clk);
    end
    ovr_en = 1'b0;
  endtask

  initial begin
    logic [127:0] d255, dcol, dramp;
    logic seen;
    d255 = {16{8'hFF}};
    dcol = '0;
    dcol[8*1 +: 8] = 8'd20; dcol[8*5 +: 8] = 8'd30;
    dcol[8*9 +: 8] = 8'd25; dcol[8*13 +: 8] = 8'd55;
    for (int i = 0; i < 16; i++) dramp[8*i +: 8] = 8'(16*(i/4) + (i%4) + 1);

    vecs[0] = mk(d255,  1'b0, 17'd0,      {4{15'd32640}}, 8'd255);
    vecs[1] = mk(dcol,  1'b0, 17'd0,      {15'd7040, 15'd3200, 15'd3840, 15'd2560}, 8'd30);
    vecs[2] = mk(dramp, 1'b0, 17'd0,      {15'd6400, 15'd4352, 15'd2304, 15'd256}, 8'd18);
    vecs[3] = mk(d255,  1'b1, 17'h1FF80,  {4{15'd0}},     8'd0);
    vecs[4] = mk(d255,  1'b1, 17'h0FFFF,  {4{15'd32767}}, 8'd255);
    vecs[5] = mk(dramp, 1'b1, 17'd2624,   {4{15'd2624}},  8'd21);
    vecs[6] = mk(dramp, 1'b1, 17'd2623,   {4{15'd2623}},  8'd20);

    repeat (2) @(negedge clk);
    chk("rst_win_ready", win_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_issue", wt_issue, 0);
    chk("rst_taps", taps, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_window(vecs[i], i);

    // Back-pressure: output held, extra window ignored, accepted only after release.
    @(negedge clk);
    out_ready = 1'b0; win_valid = 1'b1; win_data = d255;
    @(negedge clk);
    win_data = dcol;
    repeat (7) @(negedge clk);
    chk("bp_valid_T8", out_valid, 1);
    chk("bp_pixel_T8", out_pixel, 255);
    for (int s = 1; s <= 5; s++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_hold%0d", s), out_valid, 1);
      chk($sformatf("bp_pixel_hold%0d", s), out_pixel, 255);
      chk($sformatf("bp_win_ready%0d", s), win_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", win_ready, 1);
    chk("bp_release_busy", busy, 0);
    @(negedge clk);
    win_valid = 1'b0; win_data = '0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("bp2_valid_T%0d", k), out_valid, k == 8);
      if (k == 8) chk("bp2_pixel", out_pixel, 30);
      else @(negedge clk);
    end
    @(negedge clk);

    // Reset in the middle of the row passes.
    win_valid = 1'b1; win_data = d255;
    @(negedge clk);
    win_valid = 1'b0; win_data = '0;
    @(negedge clk);
    chk("ab_busy_T2", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_win_ready", win_ready, 1);
    chk("ab_busy", busy, 0);
    chk("ab_issue", wt_issue, 0);
    chk("ab_taps", taps, 0);
    chk("ab_out_valid", out_valid, 0);
    chk("ab_out_pixel", out_pixel, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("ab_no_output", seen, 0);
    do_window(vecs[0], 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
